spine_switch_router: RTL and testbench
======================================

Name: spine_switch_router

Overview:
Spine-side switch forming the far end of the leaf-to-spine links in group 4. It receives flits from four leaf routers, buffers each in a per-port input FIFO, and routes each flit by a destination field embedded in the flit. Per-output round-robin arbitration resolves contention. Each flit is returned to the target leaf with data, valid and dest_addr, matching the leaf router's spine input port. No ready/backpressure exists on the links, so overflow is dropped and counted.

Parameters:
DWIDTH, 16, flit width; dest field = data[DWIDTH-1 -: 6]
FIFO_DEPTH, 8, entries per input FIFO; power of two, >=2
GROUP_ID, 4'b0100, group served; dest[5:2] must match
SPINE_ID, 1, spine index; informational, no logic effect

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
arb_enable  in  1  1 = arbitration and dequeue allowed
leaf_in_data  in  4*DWIDTH  flit from leaf p at [p*DWIDTH +: DWIDTH]
leaf_in_valid  in  4  per-leaf flit valid
leaf_out_data  out  4*DWIDTH  flit to leaf p
leaf_out_valid  out  4  per-leaf output valid
leaf_out_dest_addr  out  24  6-bit dest field per leaf, [p*6 +: 6]
fifo_full  out  4  per-input FIFO full
fifo_empty  out  4  per-input FIFO empty
drop_count  out  8  saturating count of flits dropped on full FIFO
misroute_count  out  8  saturating count of flits dropped on group mismatch
busy  out  1  any FIFO non-empty or any leaf_out_valid high

Behaviour:
- Reset (async, active-high) forces the following, even mid-transfer; in-flight flits are lost:
  - all FIFOs flushed; fifo_empty=4'hF, fifo_full=0
  - leaf_out_data, leaf_out_valid and leaf_out_dest_addr = 0
  - all counters = 0; all RR pointers = 0; busy=0
- Ingress, each posedge, per port p with leaf_in_valid[p]=1:
  - d = data[DWIDTH-1 -: 6]
  - d[5:2] != GROUP_ID -> flit not written; misroute_count++ (saturates at 255)
  - FIFO full and no pop this cycle -> flit not written; drop_count++ (saturates at 255)
  - push and pop in the same cycle on a full FIFO -> flit accepted, not dropped
  - otherwise flit written
- Routing: head of FIFO p requests output d[1:0] (leaf index 0..3). Return to the source leaf is allowed.
- Arbitration (combinational, per output o, only when arb_enable=1):
  - search requesters starting at rr_ptr[o], then wrapping (ptr, ptr+1, ... mod 4)
  - first requester wins and is popped
  - rr_ptr[o] <= winner+1 mod 4; pointer is unchanged when there is no grant
  - each input requests only one output, so an input pops at most one flit per cycle
- Egress registered:
  - leaf_out_valid[o] <= granted
  - leaf_out_data[o] / leaf_out_dest_addr[o] <= winner's flit / dest field
  - when not granted: valid=0, data and dest hold their last value
- Latency: flit sampled at edge k; leaf_out_valid high after edge k+1 if uncontested (2 edges).
- arb_enable=0: no grants and all leaf_out_valid=0 from the next edge; FIFOs keep filling and may drop.
- Throughput: one flit per output per cycle; up to four outputs in parallel.
- FIFO pointers are log2(FIFO_DEPTH)+1 bits wide; full/empty are derived from the MSB compare and wrap correctly.
- Counters increment at most once per cycle even if several ports drop in that cycle. A drop on any port counts as 1.

Test Plan:
1. Reset asserted mid-stream with flits queued -> all outputs 0 and fifo_empty=4'hF immediately (asynchronous); after release, no stale flit appears.
2. Single flit 16'h4ABC on leaf 0 (dest 6'b010010 -> leaf 2), arb_enable=1 -> leaf_out_valid=4'b0100 after 2 edges, data 16'h4ABC, dest_addr[2]=6'h12.
3. Leaves 0-3 each send 16'h4400 (dest leaf 1) in the same cycle -> leaf 1 output delivers from inputs 0,1,2,3 in order on 4 consecutive cycles; rr_ptr[1] ends at 0.
4. Leaf 3 sends 16'h8000 (group 4'b1000) -> no output; misroute_count=1.
5. arb_enable=0, leaf 0 sends 10 flits to leaf 0 -> fifo_full[0]=1 after 8; drop_count=2. Then arb_enable=1 -> 8 flits drained in order.
6. Full FIFO with simultaneous pop and push (arb_enable=1) -> no drop; order preserved; fifo_full stays 1.

Source files
------------

// File: rtl/spine_switch_router.sv
// Spine-side switch for the group-4 leaf-to-spine links. Each leaf has an input FIFO, and each
// output leaf has a round-robin arbiter. Flits go back to the leaf named in their dest field.
module spine_switch_router #(
  parameter int         DWIDTH     = 16,
  parameter int         FIFO_DEPTH = 8,
  parameter logic [3:0] GROUP_ID   = 4'b0100,
  parameter int         SPINE_ID   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  arb_enable,
  input  logic [4*DWIDTH-1:0]   leaf_in_data,
  input  logic [3:0]            leaf_in_valid,
  output logic [4*DWIDTH-1:0]   leaf_out_data,
  output logic [3:0]            leaf_out_valid,
  output logic [23:0]           leaf_out_dest_addr,
  output logic [3:0]            fifo_full,
  output logic [3:0]            fifo_empty,
  output logic [7:0]            drop_count,
  output logic [7:0]            misroute_count,
  output logic                  busy
);

  localparam int AW = $clog2(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || SPINE_ID < 0) begin : g_param_check
    $error("spine_switch_router: FIFO_DEPTH must be a power of two >= 2 and SPINE_ID >= 0");
  end

  logic [DWIDTH-1:0] r_mem [4][FIFO_DEPTH];
  logic [AW:0]       r_wptr [4];
  logic [AW:0]       r_rptr [4];
  logic [1:0]        r_rr_ptr [4];
  logic [DWIDTH-1:0] r_out_data [4];
  logic [5:0]        r_out_dest [4];
  logic [3:0]        r_out_valid;
  logic [7:0]        r_drop_cnt;
  logic [7:0]        r_mis_cnt;

  logic [DWIDTH-1:0] w_in [4];
  logic [DWIDTH-1:0] w_head [4];
  logic [3:0]        w_empty;
  logic [3:0]        w_full;
  logic [3:0]        w_req [4];
  logic [3:0]        w_grant;
  logic [1:0]        w_winner [4];
  logic [3:0]        w_pop;
  logic [3:0]        w_push;
  logic [3:0]        w_misroute;
  logic [3:0]        w_drop;

  // FIFO status, head flit and unpacked ingress flits
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_in[p]    = leaf_in_data[p*DWIDTH +: DWIDTH];
      w_empty[p] = (r_wptr[p] == r_rptr[p]);
      w_full[p]  = (r_wptr[p][AW] != r_rptr[p][AW]) &&
                   (r_wptr[p][AW-1:0] == r_rptr[p][AW-1:0]);
      w_head[p]  = r_mem[p][r_rptr[p][AW-1:0]];
    end
  end

  // Head-of-line requests: input p asks for output dest[1:0]
  always_comb begin
    for (int o = 0; o < 4; o++) begin
      for (int p = 0; p < 4; p++) begin
        w_req[o][p] = arb_enable && !w_empty[p] &&
                      (w_head[p][DWIDTH-5 -: 2] == 2'(o));
      end
    end
  end

  // Round-robin search per output starting at its pointer
  always_comb begin
    logic [1:0] idx;
    logic       hit;
    for (int o = 0; o < 4; o++) begin
      w_grant[o]  = 1'b0;
      w_winner[o] = 2'b00;
      for (int k = 0; k < 4; k++) begin
        idx         = r_rr_ptr[o] + 2'(k);
        hit         = !w_grant[o] && w_req[o][idx];
        w_winner[o] = hit ? idx : w_winner[o];
        w_grant[o]  = w_grant[o] | hit;
      end
    end
  end

  // Pop decode and ingress accept/drop/misroute classification
  always_comb begin
    for (int p = 0; p < 4; p++) begin
      w_pop[p] = 1'b0;
      for (int o = 0; o < 4; o++) begin
        w_pop[p] = w_pop[p] | (w_grant[o] && (w_winner[o] == 2'(p)));
      end
      w_misroute[p] = leaf_in_valid[p] && (w_in[p][DWIDTH-1 -: 4] != GROUP_ID);
      // A pop in the same cycle frees a slot, so a full FIFO still accepts
      w_drop[p]     = leaf_in_valid[p] && !w_misroute[p] && w_full[p] && !w_pop[p];
      w_push[p]     = leaf_in_valid[p] && !w_misroute[p] && (!w_full[p] || w_pop[p]);
    end
  end

  // FIFO read/write pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < 4; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (w_push[p]) begin
          r_wptr[p] <= r_wptr[p] + 1'b1;
        end
        if (w_pop[p]) begin
          r_rptr[p] <= r_rptr[p] + 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk) begin
    for (int p = 0; p < 4; p++) begin
      if (w_push[p]) begin
        r_mem[p][r_wptr[p][AW-1:0]] <= w_in[p];
      end
    end
  end

  // Arbiter pointers and registered egress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out_valid <= 4'b0000;
      for (int o = 0; o < 4; o++) begin
        r_rr_ptr[o]   <= 2'b00;
        r_out_data[o] <= '0;
        r_out_dest[o] <= 6'b000000;
      end
    end else begin
      r_out_valid <= w_grant;
      for (int o = 0; o < 4; o++) begin
        if (w_grant[o]) begin
          r_rr_ptr[o]   <= w_winner[o] + 2'b01;
          r_out_data[o] <= w_head[w_winner[o]];
          r_out_dest[o] <= w_head[w_winner[o]][DWIDTH-1 -: 6];
        end
      end
    end
  end

  // Saturating drop and misroute counters, at most one step per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_drop_cnt <= 8'h00;
      r_mis_cnt  <= 8'h00;
    end else begin
      if ((|w_drop) && (r_drop_cnt != 8'hFF)) begin
        r_drop_cnt <= r_drop_cnt + 8'h01;
      end
      if ((|w_misroute) && (r_mis_cnt != 8'hFF)) begin
        r_mis_cnt <= r_mis_cnt + 8'h01;
      end
    end
  end

  // Output packing
  always_comb begin
    for (int o = 0; o < 4; o++) begin
      leaf_out_data[o*DWIDTH +: DWIDTH] = r_out_data[o];
      leaf_out_dest_addr[o*6 +: 6]      = r_out_dest[o];
    end
  end

  assign leaf_out_valid = r_out_valid;
  assign fifo_full      = w_full;
  assign fifo_empty     = w_empty;
  assign drop_count     = r_drop_cnt;
  assign misroute_count = r_mis_cnt;
  assign busy           = (~&w_empty) || (|r_out_valid);

endmodule

// File: tb/tb_spine_switch_router.sv
// Directed testbench for spine_switch_router. It applies a table of single-flit vectors and then
// runs hand-written sequences for contention, overflow, full push/pop and async reset.
module tb_spine_switch_router;

  logic        clk;
  logic        reset;
  logic        arb_enable;
  logic [63:0] leaf_in_data;
  logic [3:0]  leaf_in_valid;
  logic [63:0] leaf_out_data;
  logic [3:0]  leaf_out_valid;
  logic [23:0] leaf_out_dest_addr;
  logic [3:0]  fifo_full;
  logic [3:0]  fifo_empty;
  logic [7:0]  drop_count;
  logic [7:0]  misroute_count;
  logic        busy;

  int n_checks;
  int n_errors;

  spine_switch_router #(
    .DWIDTH(16), .FIFO_DEPTH(8), .GROUP_ID(4'b0100), .SPINE_ID(1)
  ) dut (
    .clk(clk), .reset(reset), .arb_enable(arb_enable),
    .leaf_in_data(leaf_in_data), .leaf_in_valid(leaf_in_valid),
    .leaf_out_data(leaf_out_data), .leaf_out_valid(leaf_out_valid),
    .leaf_out_dest_addr(leaf_out_dest_addr),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .drop_count(drop_count), .misroute_count(misroute_count), .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int          src;
    logic [15:0] data;
    logic [3:0]  exp_valid;
    logic [5:0]  exp_dest;
    logic [7:0]  exp_mis;
  } vec_t;

  vec_t vecs [7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input int src, input logic [15:0] data);
    leaf_in_data[src*16 +: 16] = data;
    leaf_in_valid[src]         = 1'b1;
  endtask

  task automatic idle_in();
    leaf_in_valid = 4'b0000;
    leaf_in_data  = 64'h0;
  endtask

  function automatic logic [15:0] out_data(input int o);
    return leaf_out_data[o*16 +: 16];
  endfunction

  function automatic logic [5:0] out_dest(input int o);
    return leaf_out_dest_addr[o*6 +: 6];
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    arb_enable = 1'b0;
    idle_in();

    vecs[0] = '{0, 16'h4ABC, 4'b0100, 6'h12, 8'd0};
    vecs[1] = '{1, 16'h4123, 4'b0001, 6'h10, 8'd0};
    vecs[2] = '{2, 16'h4E55, 4'b1000, 6'h13, 8'd0};
    vecs[3] = '{3, 16'h47FF, 4'b0010, 6'h11, 8'd0};
    vecs[4] = '{3, 16'h8000, 4'b0000, 6'h00, 8'd1};
    vecs[5] = '{1, 16'h0C00, 4'b0000, 6'h00, 8'd2};
    vecs[6] = '{2, 16'h4800, 4'b0100, 6'h12, 8'd2};

    tick();
    tick();
    reset = 1'b0;
    chk("reset_valid", 64'(leaf_out_valid), 64'h0);
    chk("reset_data", leaf_out_data, 64'h0);
    chk("reset_dest", 64'(leaf_out_dest_addr), 64'h0);
    chk("reset_empty", 64'(fifo_empty), 64'hF);
    chk("reset_full", 64'(fifo_full), 64'h0);
    chk("reset_drop", 64'(drop_count), 64'h0);
    chk("reset_mis", 64'(misroute_count), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);

    // Single-flit vectors: the flit should come out two edges after it is driven
    arb_enable = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].src, vecs[i].data);
      tick();
      idle_in();
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(leaf_out_valid), 64'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_mis", i), 64'(misroute_count), 64'(vecs[i].exp_mis));
      for (int o = 0; o < 4; o++) begin
        if (vecs[i].exp_valid[o]) begin
          chk($sformatf("vec%0d_data", i), 64'(out_data(o)), 64'(vecs[i].data));
          chk($sformatf("vec%0d_dest", i), 64'(out_dest(o)), 64'(vecs[i].exp_dest));
        end
      end
      tick();
      chk($sformatf("vec%0d_valid_drop", i), 64'(leaf_out_valid), 64'h0);
      for (int o = 0; o < 4; o++) begin
        if (vecs[i].exp_valid[o]) begin
          chk($sformatf("vec%0d_data_hold", i), 64'(out_data(o)), 64'(vecs[i].data));
        end
      end
    end

    // Four-way contention for leaf 1
    for (int p = 0; p < 4; p++) send(p, 16'h4400 + 16'(p));
    tick();
    idle_in();
    for (int p = 0; p < 4; p++) begin
      tick();
      chk($sformatf("rr_valid%0d", p), 64'(leaf_out_valid), 64'h2);
      chk($sformatf("rr_data%0d", p), 64'(out_data(1)), 64'(16'h4400 + 16'(p)));
    end
    tick();
    chk("rr_idle", 64'(leaf_out_valid), 64'h0);
    // The pointer should be back at 0, so input 0 beats input 3
    send(3, 16'h4433);
    send(0, 16'h4430);
    tick();
    idle_in();
    tick();
    chk("rr_ptr_first", 64'(out_data(1)), 64'h4430);
    tick();
    chk("rr_ptr_second", 64'(out_data(1)), 64'h4433);
    chk("rr_ptr_second_v", 64'(leaf_out_valid), 64'h2);
    tick();

    // Overflow with arbitration disabled
    arb_enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      send(0, 16'h4000 + 16'(i));
      tick();
      if (i == 6) chk("ovf_full_at7", 64'(fifo_full[0]), 64'h0);
      if (i == 7) chk("ovf_full_at8", 64'(fifo_full[0]), 64'h1);
      chk($sformatf("ovf_novalid%0d", i), 64'(leaf_out_valid), 64'h0);
    end
    idle_in();
    chk("ovf_drop", 64'(drop_count), 64'd2);
    chk("ovf_busy", 64'(busy), 64'h1);
    arb_enable = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("drain_valid%0d", i), 64'(leaf_out_valid), 64'h1);
      chk($sformatf("drain_data%0d", i), 64'(out_data(0)), 64'(16'h4000 + 16'(i)));
    end
    tick();
    chk("drain_done_valid", 64'(leaf_out_valid), 64'h0);
    chk("drain_done_empty", 64'(fifo_empty), 64'hF);

    // Full FIFO accepting a push in the same cycle as a pop
    arb_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      send(0, 16'h4100 + 16'(i));
      tick();
    end
    chk("pp_full_pre", 64'(fifo_full[0]), 64'h1);
    arb_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(0, 16'h4108 + 16'(i));
      tick();
      chk($sformatf("pp_full%0d", i), 64'(fifo_full[0]), 64'h1);
      chk($sformatf("pp_data%0d", i), 64'(out_data(0)), 64'(16'h4100 + 16'(i)));
    end
    idle_in();
    chk("pp_nodrop", 64'(drop_count), 64'd2);
    for (int i = 3; i < 11; i++) begin
      tick();
      chk($sformatf("pp_tail%0d", i), 64'(out_data(0)), 64'(16'h4100 + 16'(i)));
      chk($sformatf("pp_tail_v%0d", i), 64'(leaf_out_valid), 64'h1);
    end
    tick();
    chk("pp_end_empty", 64'(fifo_empty[0]), 64'h1);

    // Asynchronous reset mid-stream with flits queued
    arb_enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(1, 16'h4200 + 16'(i));
      tick();
    end
    idle_in();
    arb_enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("areset_empty", 64'(fifo_empty), 64'hF);
    chk("areset_full", 64'(fifo_full), 64'h0);
    chk("areset_valid", 64'(leaf_out_valid), 64'h0);
    chk("areset_data", leaf_out_data, 64'h0);
    chk("areset_dest", 64'(leaf_out_dest_addr), 64'h0);
    chk("areset_drop", 64'(drop_count), 64'h0);
    chk("areset_mis", 64'(misroute_count), 64'h0);
    chk("areset_busy", 64'(busy), 64'h0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("post_reset_valid%0d", i), 64'(leaf_out_valid), 64'h0);
      chk($sformatf("post_reset_empty%0d", i), 64'(fifo_empty), 64'hF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
